// File: rtl/lc3b_ctrl_pipe_pkg.sv
// rtl/lc3b_ctrl_pipe_pkg.sv - LC-3b shared types for the pipelined control decoder
package lc3b_types;

   typedef enum logic [3:0] {
      op_br   = 4'h0,
      op_add  = 4'h1,
      op_ldb  = 4'h2,
      op_stb  = 4'h3,
      op_jsr  = 4'h4,
      op_and  = 4'h5,
      op_ldr  = 4'h6,
      op_str  = 4'h7,
      op_rti  = 4'h8,
      op_not  = 4'h9,
      op_ldi  = 4'hA,
      op_sti  = 4'hB,
      op_jmp  = 4'hC,
      op_shf  = 4'hD,
      op_lea  = 4'hE,
      op_trap = 4'hF
   } lc3b_opcode;

   typedef enum logic [2:0] {
      alu_add  = 3'd0,
      alu_and  = 3'd1,
      alu_not  = 3'd2,
      alu_sll  = 3'd3,
      alu_srl  = 3'd4,
      alu_sra  = 3'd5,
      alu_pass = 3'd6
   } lc3b_aluop;

   typedef struct packed {
      lc3b_opcode opcode;
      lc3b_aluop  aluop;
      logic       sr2mux_sel;
      logic       load_cc;
      logic       load_regfile;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       indirect_step;
   } lc3b_control_word;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_IND2 = 1'b1
   } lc3b_seq_state;

endpackage

// File: rtl/lc3b_ctrl_pipe_decode.sv
// rtl/lc3b_ctrl_pipe_decode.sv - combinational LC-3b instruction to control-word decoder
module lc3b_ctrl_decode
   import lc3b_types::*;
(
   input  logic [15:0]      i_ir,
   input  logic             i_indirect_step,
   output lc3b_control_word o_ctrl,
   output logic             o_supported
);

   // Only the opcode and the immediate select steer the control word.
   logic w_unused_ir;
   assign w_unused_ir = ^{i_ir[11:6], i_ir[4:0]};

   // Table decode; every field defaults to zero except the opcode.
   always_comb begin
      o_ctrl        = '0;
      o_supported   = 1'b1;
      o_ctrl.opcode = lc3b_opcode'(i_ir[15:12]);
      case (o_ctrl.opcode)
         op_add, op_and: begin
            o_ctrl.aluop        = (o_ctrl.opcode == op_add) ? alu_add : alu_and;
            o_ctrl.sr2mux_sel   = i_ir[5];
            o_ctrl.load_regfile = 1'b1;
            o_ctrl.load_cc      = 1'b1;
         end
         op_not: begin
            o_ctrl.aluop        = alu_not;
            o_ctrl.load_regfile = 1'b1;
            o_ctrl.load_cc      = 1'b1;
         end
         op_ldr: begin
            o_ctrl.aluop        = alu_add;
            o_ctrl.mem_read     = 1'b1;
            o_ctrl.load_regfile = 1'b1;
            o_ctrl.load_cc      = 1'b1;
         end
         op_str: begin
            o_ctrl.aluop     = alu_add;
            o_ctrl.mem_write = 1'b1;
         end
         op_br: begin
            o_ctrl.aluop  = alu_pass;
            o_ctrl.branch = 1'b1;
         end
         op_ldi, op_sti: begin
            if (!i_indirect_step) begin
               // First micro-op: compute the pointer address and read it.
               o_ctrl.aluop    = alu_add;
               o_ctrl.mem_read = 1'b1;
            end else begin
               // Second micro-op: use the fetched pointer as the address.
               o_ctrl.aluop         = alu_pass;
               o_ctrl.indirect_step = 1'b1;
               if (o_ctrl.opcode == op_ldi) begin
                  o_ctrl.mem_read     = 1'b1;
                  o_ctrl.load_regfile = 1'b1;
                  o_ctrl.load_cc      = 1'b1;
               end else begin
                  o_ctrl.mem_write = 1'b1;
               end
            end
         end
         default: o_supported = 1'b0;
      endcase
   end

endmodule

// File: rtl/lc3b_ctrl_pipe.sv
// rtl/lc3b_ctrl_pipe.sv - LC-3b control pipeline with indirect sequencer, stall and partial flush
module lc3b_ctrl_pipe
   import lc3b_types::*;
#(
   parameter int STAGES       = 4,
   parameter int FLUSH_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [15:0]                    ir,
   input  logic                           stall,
   input  logic                           flush,
   output logic [STAGES-1:0]              stage_valid,
   output lc3b_control_word [STAGES-1:0]  stage_ctrl,
   output logic                           illegal
);

   lc3b_seq_state                 r_state;
   lc3b_seq_state                 w_state_next;
   logic [15:0]                   r_ir;
   logic                          r_illegal;
   logic [STAGES-1:0]             r_valid;
   lc3b_control_word [STAGES-1:0] r_ctrl;

   logic             w_accept;
   logic             w_is_indirect;
   logic             w_emit_step1;
   logic             w_in_valid;
   logic [15:0]      w_dec_ir;
   lc3b_control_word w_dec_word;
   logic             w_dec_supported;

   assign in_ready      = !rst && !stall && !flush && (r_state == SEQ_IDLE);
   assign w_accept      = in_valid && in_ready;
   assign w_is_indirect = (ir[15:12] == op_ldi) || (ir[15:12] == op_sti);
   assign w_emit_step1  = !rst && !stall && !flush && (r_state == SEQ_IND2);
   assign w_dec_ir      = (r_state == SEQ_IND2) ? r_ir : ir;
   // Unsupported opcodes still enter stage 0, but as a bubble.
   assign w_in_valid    = (w_accept && w_dec_supported) || w_emit_step1;

   lc3b_ctrl_decode u_decode (
      .i_ir            (w_dec_ir),
      .i_indirect_step (r_state == SEQ_IND2),
      .o_ctrl          (w_dec_word),
      .o_supported     (w_dec_supported)
   );

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= SEQ_IDLE;
      else     r_state <= w_state_next;
   end

   // Sequencer next state: flush abandons a pending step1, stall holds it.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SEQ_IDLE: if (w_accept && w_is_indirect) w_state_next = SEQ_IND2;
         SEQ_IND2: if (flush || !stall)           w_state_next = SEQ_IDLE;
         default:                                 w_state_next = SEQ_IDLE;
      endcase
   end

   // Latch the indirect instruction so step1 can be decoded after ir moves on.
   always_ff @(posedge clk) begin
      if (rst)                            r_ir <= '0;
      else if (w_accept && w_is_indirect) r_ir <= ir;
   end

   // One-cycle pulse for each accepted unsupported opcode.
   always_ff @(posedge clk) begin
      if (rst) r_illegal <= 1'b0;
      else     r_illegal <= w_accept && !w_dec_supported;
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam bit L_YOUNG    = (i < FLUSH_STAGES);
      localparam bit L_BOUNDARY = (i == FLUSH_STAGES);
      logic             w_src_valid;
      lc3b_control_word w_src_ctrl;

      if (i == 0) begin : g_head
         assign w_src_valid = w_in_valid;
         assign w_src_ctrl  = w_dec_word;
      end else begin : g_body
         assign w_src_valid = r_valid[i-1];
         assign w_src_ctrl  = r_ctrl[i-1];
      end

      // Stage register: flush squashes young stages even under stall; the
      // first older stage takes a bubble so a squashed word cannot leak past.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_valid[i] <= 1'b0;
            r_ctrl[i]  <= '0;
         end else if (flush && L_YOUNG) begin
            r_valid[i] <= 1'b0;
         end else if (!stall) begin
            r_valid[i] <= w_src_valid && !(flush && L_BOUNDARY);
            r_ctrl[i]  <= w_src_ctrl;
         end
      end
   end

   assign stage_valid = r_valid;
   assign stage_ctrl  = r_ctrl;
   assign illegal     = r_illegal;

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// tb/tb_lc3b_ctrl_pipe.sv - randomized self-checking bench for lc3b_ctrl_pipe
module tb_lc3b_ctrl_pipe;
   import lc3b_types::*;

   localparam int NS = 4;
   localparam int FL = 2;

   logic                       clk = 1'b0;
   logic                       rst, in_valid, stall, flush;
   logic [15:0]                ir;
   logic                       in_ready, illegal;
   logic [NS-1:0]              stage_valid;
   lc3b_control_word [NS-1:0]  stage_ctrl;

   lc3b_ctrl_pipe #(.STAGES(NS), .FLUSH_STAGES(FL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
      .stall(stall), .flush(flush), .stage_valid(stage_valid),
      .stage_ctrl(stage_ctrl), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit               mv[NS];
   lc3b_control_word mc[NS];
   bit               m_pend;
   logic [15:0]      m_ir;
   bit               m_ill;
   bit               exp_ready, obs_ready;
   int               n_checks = 0;
   int               n_fail = 0;

   function automatic bit ref_ok(logic [3:0] op);
      return op inside {4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB};
   endfunction

   function automatic lc3b_control_word ref_word(logic [15:0] x, bit step);
      lc3b_control_word c;
      c = '0;
      c.opcode = lc3b_opcode'(x[15:12]);
      case (x[15:12])
         4'h1: begin c.aluop = alu_add; c.sr2mux_sel = x[5]; c.load_regfile = 1; c.load_cc = 1; end
         4'h5: begin c.aluop = alu_and; c.sr2mux_sel = x[5]; c.load_regfile = 1; c.load_cc = 1; end
         4'h9: begin c.aluop = alu_not; c.load_regfile = 1; c.load_cc = 1; end
         4'h6: begin c.aluop = alu_add; c.mem_read = 1; c.load_regfile = 1; c.load_cc = 1; end
         4'h7: begin c.aluop = alu_add; c.mem_write = 1; end
         4'h0: begin c.aluop = alu_pass; c.branch = 1; end
         4'hA, 4'hB: begin
            if (!step) begin
               c.aluop = alu_add; c.mem_read = 1;
            end else begin
               c.aluop = alu_pass; c.indirect_step = 1;
               if (x[15:12] == 4'hA) begin c.mem_read = 1; c.load_regfile = 1; c.load_cc = 1; end
               else c.mem_write = 1;
            end
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [15:0] rand_ir();
      logic [3:0] ops [11];
      logic [15:0] r;
      ops = '{4'h1, 4'h5, 4'h9, 4'h6, 4'h7, 4'h0, 4'hA, 4'hB, 4'hD, 4'hF, 4'h2};
      r = 16'($urandom);
      r[15:12] = ops[$urandom_range(0, 10)];
      return r;
   endfunction

   function automatic bit chain_ok();
      for (int k = 0; k < NS; k++) begin
         if (stage_valid[k] !== mv[k]) return 0;
         if (mv[k] && stage_ctrl[k] !== mc[k]) return 0;
      end
      return 1;
   endfunction

   // Apply the current inputs for one clock; model follows the rules in words.
   task automatic tick();
      bit wv, acc;
      lc3b_control_word w;
      #1;
      obs_ready = in_ready;
      exp_ready = !rst && !stall && !flush && !m_pend;
      if (rst) begin
         for (int k = 0; k < NS; k++) begin mv[k] = 0; mc[k] = '0; end
         m_pend = 0; m_ill = 0;
      end else begin
         acc = in_valid && exp_ready;
         wv = 0; w = '0;
         if (m_pend) begin
            if (!stall && !flush) begin wv = 1; w = ref_word(m_ir, 1); m_pend = 0; end
            else if (flush) m_pend = 0;
         end
         m_ill = acc && !ref_ok(ir[15:12]);
         if (acc) begin
            w = ref_word(ir, 0);
            wv = ref_ok(ir[15:12]);
            if (ir[15:12] == 4'hA || ir[15:12] == 4'hB) begin m_pend = 1; m_ir = ir; end
         end
         if (!stall) begin
            for (int k = NS - 1; k > 0; k--) begin mv[k] = mv[k-1]; mc[k] = mc[k-1]; end
            mv[0] = wv; mc[0] = w;
         end
         if (flush) begin
            for (int k = 0; k < FL; k++) mv[k] = 0;
            if (!stall && FL < NS) mv[FL] = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; stall = 0; flush = 0; rst = 0; ir = 16'h0000;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      n_checks++;
      if (stage_valid !== '0 || stage_ctrl !== '0 || illegal !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: valid=%b ctrl=%h ill=%b required 0", stage_valid, stage_ctrl, illegal);
      end
      n_checks++;
      if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", obs_ready); end
      rst = 0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", in_ready); end
   endtask

   task automatic test_add();
      idle_inputs();
      in_valid = 1; ir = 16'h1042;
      tick();
      in_valid = 0;
      n_checks++;
      if (stage_valid[0] !== 1'b1 || stage_ctrl[0].aluop !== alu_add || stage_ctrl[0].sr2mux_sel !== 1'b0 ||
          stage_ctrl[0].load_regfile !== 1'b1 || stage_ctrl[0].load_cc !== 1'b1) begin
         n_fail++; $display("FAIL add_stage0: valid=%b ctrl=%h", stage_valid[0], stage_ctrl[0]);
      end
      for (int c = 0; c < 3; c++) tick();
      n_checks++;
      if (stage_valid[3] !== 1'b1 || stage_ctrl[3] !== ref_word(16'h1042, 0)) begin
         n_fail++; $display("FAIL add_latency: stage3 valid=%b ctrl=%h required 1/%h", stage_valid[3], stage_ctrl[3], ref_word(16'h1042, 0));
      end
      in_valid = 1; ir = 16'h1061;
      tick();
      in_valid = 0;
      n_checks++;
      if (stage_valid[0] !== 1'b1 || stage_ctrl[0].sr2mux_sel !== 1'b1) begin
         n_fail++; $display("FAIL add_imm: valid=%b sr2mux=%b required 1/1", stage_valid[0], stage_ctrl[0].sr2mux_sel);
      end
   endtask

   task automatic test_indirect();
      idle_inputs();
      in_valid = 1; ir = 16'hA040;
      tick();
      ir = 16'h907F;
      n_checks++;
      if (in_ready !== 1'b0 || stage_valid[0] !== 1'b1 || stage_ctrl[0].mem_read !== 1'b1 ||
          stage_ctrl[0].load_regfile !== 1'b0 || stage_ctrl[0].indirect_step !== 1'b0) begin
         n_fail++; $display("FAIL ldi_step0: ready=%b valid=%b ctrl=%h", in_ready, stage_valid[0], stage_ctrl[0]);
      end
      tick();
      n_checks++;
      if (stage_valid[0] !== 1'b1 || stage_ctrl[0].load_regfile !== 1'b1 || stage_ctrl[0].indirect_step !== 1'b1 ||
          stage_ctrl[0].aluop !== alu_pass) begin
         n_fail++; $display("FAIL ldi_step1: valid=%b ctrl=%h", stage_valid[0], stage_ctrl[0]);
      end
      tick();
      in_valid = 0;
      n_checks++;
      if (stage_valid[0] !== 1'b1 || stage_ctrl[0].aluop !== alu_not || !chain_ok()) begin
         n_fail++; $display("FAIL ldi_then_not: valid=%b ctrl=%h required aluop not", stage_valid[0], stage_ctrl[0]);
      end
   endtask

   task automatic test_stall();
      logic [NS-1:0]             sv;
      lc3b_control_word [NS-1:0] sc;
      idle_inputs();
      for (int c = 0; c < NS; c++) begin in_valid = 1; ir = {4'h1, 12'($urandom)}; tick(); end
      in_valid = 1; ir = 16'h5123; stall = 1;
      sv = stage_valid; sc = stage_ctrl;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (stage_valid !== sv || stage_ctrl !== sc || obs_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: valid=%b ready=%b required %b/0", stage_valid, obs_ready, sv);
         end
      end
      stall = 0;
      tick();
      in_valid = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (!chain_ok()) begin n_fail++; $display("FAIL stall_resume: valid=%b ctrl=%h", stage_valid, stage_ctrl); end
      end
   endtask

   task automatic test_flush_ind2();
      lc3b_control_word c2;
      idle_inputs();
      for (int c = 0; c < 3; c++) begin in_valid = 1; ir = {4'h5, 12'($urandom)}; tick(); end
      ir = 16'hA040;
      tick();
      in_valid = 0;
      c2 = stage_ctrl[2];
      flush = 1;
      tick();
      flush = 0;
      n_checks++;
      if (stage_valid !== 4'b1000 || stage_ctrl[3] !== c2) begin
         n_fail++; $display("FAIL flush_ind2: valid=%b s3=%h required 1000/%h", stage_valid, stage_ctrl[3], c2);
      end
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: ready=%b required 1", in_ready); end
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (stage_valid[0] !== 1'b0 || !chain_ok()) begin
            n_fail++; $display("FAIL flush_no_step1: valid=%b ctrl0=%h", stage_valid, stage_ctrl[0]);
         end
      end
   endtask

   task automatic test_illegal();
      idle_inputs();
      in_valid = 1; ir = 16'hF025;
      tick();
      ir = 16'h1042;
      n_checks++;
      if (illegal !== 1'b1 || stage_valid[0] !== 1'b0) begin
         n_fail++; $display("FAIL trap_illegal: ill=%b valid0=%b required 1/0", illegal, stage_valid[0]);
      end
      tick();
      in_valid = 0;
      n_checks++;
      if (illegal !== 1'b0 || stage_valid[0] !== 1'b1 || stage_ctrl[0] !== ref_word(16'h1042, 0)) begin
         n_fail++; $display("FAIL after_trap: ill=%b valid0=%b ctrl0=%h", illegal, stage_valid[0], stage_ctrl[0]);
      end
   endtask

   task automatic test_rst_mid();
      idle_inputs();
      for (int c = 0; c < 3; c++) begin in_valid = 1; ir = {4'h6, 12'($urandom)}; tick(); end
      ir = 16'hB1C0;
      tick();
      in_valid = 0; rst = 1;
      tick();
      n_checks++;
      if (stage_valid !== '0 || illegal !== 1'b0 || obs_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid: valid=%b ill=%b ready=%b required 0/0/0", stage_valid, illegal, obs_ready);
      end
      rst = 0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b required 1", in_ready); end
      tick();
      n_checks++;
      if (stage_valid !== '0) begin n_fail++; $display("FAIL rst_mid_no_step1: valid=%b required 0", stage_valid); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst      = ($urandom_range(0, 99) < 2);
         stall    = ($urandom_range(0, 99) < 20);
         flush    = ($urandom_range(0, 99) < 10);
         in_valid = ($urandom_range(0, 99) < 75);
         ir       = rand_ir();
         tick();
         n_checks++;
         if (obs_ready !== exp_ready || illegal !== m_ill || !chain_ok()) begin
            n_fail++;
            $display("FAIL random cycle %0d: ready=%b/%b ill=%b/%b valid=%b ctrl=%h", c, obs_ready, exp_ready,
                     illegal, m_ill, stage_valid, stage_ctrl);
         end
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_indirect();
      test_stall();
      test_flush_ind2();
      test_illegal();
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
